mvts_stream_reader: RTL and testbench

- Sequencer directly upstream of the Mvts coefficient memory.
- Drives the memory's 11-bit index port and captures its combinational 13-bit data output.
- Streams the P polynomial coefficients, index 0..P-1, over a valid/ready interface to the downstream multiplier/encoder stage.
- Provides start/busy/done control, a synchronous abort, and last-beat marking.

---
 rtl/mvts_stream_reader.sv | 137 +++++++++++++
 tb/tb_mvts_stream_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvts_stream_reader.sv
// Mvts coefficient stream reader: walks the Mvts memory from index 0 to P-1
// and streams each coefficient over a valid/ready interface, with
// start/busy/done control, synchronous abort and last-beat marking.
// Optional macro MVTS_RANGE_CHECK_EN enables a sticky mem_data >= Q flag.
// Ports:
//   clk_i, rst_i             clock, async active-high reset
//   start_i, abort_i         sweep request (IDLE only), synchronous abort
//   mem_index_o, mem_data_i  Mvts memory index / combinational data
//   out_data_o, out_valid_o, out_last_o, out_ready_i  coefficient stream
//   busy_o, done_o           RUN/DRAIN indicator, end-of-sweep pulse
//   range_err_o              sticky out-of-range flag (0 if macro undefined)
module mvts_stream_reader #(
    parameter int P = 101,
    parameter int Q = 4591
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [10:0] mem_index_o,
    input  logic [12:0] mem_data_i,
    output logic [12:0] out_data_o,
    output logic        out_valid_o,
    output logic        out_last_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        range_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [10:0] LAST_IDX = 11'(P - 1);

    state_t      state_q;
    logic [10:0] idx_q;
    logic [12:0] out_data_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic        busy_q;
    logic        done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // abort beats every state transition, including a same-cycle start
            if (abort_i) begin
                state_q     <= IDLE;
                idx_q       <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            state_q <= RUN;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    RUN: begin
                        // load when the output slot is empty or being drained
                        if (!out_valid_q || out_ready_i) begin
                            out_data_q  <= mem_data_i;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (idx_q == LAST_IDX);
                            if (idx_q == LAST_IDX) begin
                                state_q <= DRAIN;
                            end else begin
                                idx_q <= idx_q + 11'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (out_valid_q && out_ready_i) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            idx_q       <= '0;
                            state_q     <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MVTS_RANGE_CHECK_EN
    logic range_err_q;
    logic load;
    logic start_ok;

    assign load     = (state_q == RUN) && !abort_i
                      && (!out_valid_q || out_ready_i);
    assign start_ok = (state_q == IDLE) && start_i && !abort_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            range_err_q <= 1'b0;
        end else if (start_ok) begin
            range_err_q <= 1'b0;
        end else if (load && (32'(mem_data_i) >= 32'(Q))) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err_o = range_err_q;
`else
    assign range_err_o = 1'b0;
`endif

    assign mem_index_o = idx_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_mvts_stream_reader.sv
// Testbench for mvts_stream_reader: random memory contents and ready
// patterns checked against a beat-level reference of the sweep.
module tb_mvts_stream_reader;

    localparam int P = 101;
    localparam int Q = 4591;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [10:0] mem_index;
    logic [12:0] mem_data;
    logic [12:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        range_err;

    logic        start1;
    logic        abort1;
    logic [10:0] mem_index1;
    logic [12:0] mem_data1;
    logic [12:0] out_data1;
    logic        out_valid1;
    logic        out_last1;
    logic        out_ready1;
    logic        busy1;
    logic        done1;
    logic        range_err1;

    logic [12:0] mem [0:2047];

    int checks   = 0;
    int failures = 0;

    assign mem_data = mem[mem_index];

    mvts_stream_reader #(.P(P), .Q(Q)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .abort_i     (abort),
        .mem_index_o (mem_index),
        .mem_data_i  (mem_data),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_last_o  (out_last),
        .out_ready_i (out_ready),
        .busy_o      (busy),
        .done_o      (done),
        .range_err_o (range_err)
    );

    mvts_stream_reader #(.P(1), .Q(Q)) u_dut_p1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start1),
        .abort_i     (abort1),
        .mem_index_o (mem_index1),
        .mem_data_i  (mem_data1),
        .out_data_o  (out_data1),
        .out_valid_o (out_valid1),
        .out_last_o  (out_last1),
        .out_ready_i (out_ready1),
        .busy_o      (busy1),
        .done_o      (done1),
        .range_err_o (range_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // flag is expected once any of the first n loaded coefficients is >= Q
    function automatic logic exp_err(input int n);
`ifdef MVTS_RANGE_CHECK_EN
        for (int i = 0; i < n; i++) begin
            if (32'(mem[i]) >= 32'(Q)) return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic fill_mem(input bit ones);
        for (int i = 0; i < 2048; i++) begin
            mem[i] = ones ? 13'd1 : 13'($urandom_range(0, Q - 1));
        end
    endtask

    // mode 0: ready high, 1: ready toggling, 2: random ready + stray starts
    // stop_at >= 0: abort (or reset if use_rst) once that many beats accepted
    task automatic sweep(input int mode, input int stop_at, input bit use_rst);
        int          beat     = 0;
        int          loaded   = 0;
        int          busy_n   = 0;
        int          n        = 0;
        bit          fin      = 0;
        bit          last_acc = 0;
        bit          stall    = 0;
        bit          rdy;
        logic [12:0] held     = '0;
        start = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!fin && n < 4000) begin
            loaded = beat + int'(out_valid);
            check("range_err", 32'(range_err), 32'(exp_err(loaded)));
            if (last_acc) begin
                check("done", 32'(done), 1);
                check("busy_end", 32'(busy), 0);
                check("valid_end", 32'(out_valid), 0);
                check("last_end", 32'(out_last), 0);
                check("beats", beat, P);
                if (mode == 0) check("busy_cycles", busy_n, P + 1);
                fin = 1;
            end else begin
                check("done_early", 32'(done), 0);
                check("busy", 32'(busy), 1);
                busy_n++;
                if (!out_valid) begin
                    check("bubble", n, 0);
                    check("idx0", 32'(mem_index), 0);
                end else begin
                    check("index", 32'(mem_index),
                          (beat + 1 < P) ? beat + 1 : P - 1);
                    check("data", 32'(out_data), 32'(mem[beat]));
                    check("last", 32'(out_last), 32'(beat == P - 1));
                    if (stall) check("stall_hold", 32'(out_data), 32'(held));
                end
                if (stop_at >= 0 && beat == stop_at) begin
                    if (use_rst) begin
                        rst = 1'b1;
                        #1;
                        check("rst_valid", 32'(out_valid), 0);
                        check("rst_busy", 32'(busy), 0);
                        check("rst_index", 32'(mem_index), 0);
                        check("rst_data", 32'(out_data), 0);
                        check("rst_last", 32'(out_last), 0);
                        check("rst_err", 32'(range_err), 0);
                        @(negedge clk);
                        rst = 1'b0;
                    end else begin
                        abort     = 1'b1;
                        out_ready = 1'($urandom % 2);
                        @(negedge clk);
                        abort = 1'b0;
                        check("abort_valid", 32'(out_valid), 0);
                        check("abort_last", 32'(out_last), 0);
                        check("abort_busy", 32'(busy), 0);
                        check("abort_done", 32'(done), 0);
                        check("abort_index", 32'(mem_index), 0);
                        check("abort_err", 32'(range_err),
                              32'(exp_err(loaded)));
                        start = 1'b1;
                        abort = 1'b1;
                        @(negedge clk);
                        start = 1'b0;
                        abort = 1'b0;
                        check("start_abort_busy", 32'(busy), 0);
                        check("start_abort_valid", 32'(out_valid), 0);
                    end
                    return;
                end
                if (mode == 0)      rdy = 1'b1;
                else if (mode == 1) rdy = (n % 2) == 0;
                else                rdy = 1'($urandom % 2);
                out_ready = rdy;
                start     = (mode == 2) && ($urandom % 4 == 0);
                stall     = out_valid && !rdy;
                held      = out_data;
                if (out_valid && rdy) begin
                    beat++;
                    if (beat == P) last_acc = 1;
                end
                n++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!fin) check("timeout", 0, 1);
    endtask

    task automatic p1_test();
        logic [12:0] v;
        v          = 13'($urandom_range(0, Q - 1));
        mem_data1  = v;
        out_ready1 = 1'b1;
        start1     = 1'b1;
        @(negedge clk);
        check("p1_busy", 32'(busy1), 1);
        check("p1_valid0", 32'(out_valid1), 0);
        @(negedge clk);
        check("p1_valid", 32'(out_valid1), 1);
        check("p1_last", 32'(out_last1), 1);
        check("p1_data", 32'(out_data1), 32'(v));
        check("p1_index", 32'(mem_index1), 0);
        @(negedge clk);
        start1 = 1'b0;
        check("p1_done", 32'(done1), 1);
        check("p1_busy_end", 32'(busy1), 0);
        check("p1_valid_end", 32'(out_valid1), 0);
        @(negedge clk);
        check("p1_done_once", 32'(done1), 0);
        check("p1_no_extra", 32'(out_valid1), 0);
        check("p1_idle", 32'(busy1), 0);
        check("p1_err", 32'(range_err1), 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        start1     = 1'b0;
        abort1     = 1'b0;
        out_ready1 = 1'b0;
        mem_data1  = '0;
        fill_mem(1'b1);
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_index", 32'(mem_index), 0);
        check("reset_data", 32'(out_data), 0);
        check("reset_last", 32'(out_last), 0);
        check("reset_err", 32'(range_err), 0);
        check("reset_p1_busy", 32'(busy1), 0);
        rst = 1'b0;
        @(negedge clk);

        sweep(0, -1, 1'b0);
        fill_mem(1'b0);
        sweep(1, -1, 1'b0);
        sweep(2, -1, 1'b0);
        sweep(2, -1, 1'b0);
        sweep(2, 40, 1'b0);
        sweep(0, -1, 1'b0);
        sweep(2, 60, 1'b1);
        sweep(1, -1, 1'b0);

        mem[7] = 13'(Q);
        sweep(2, -1, 1'b0);
        mem[7] = 13'($urandom_range(0, Q - 1));
        sweep(0, -1, 1'b0);

        p1_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
